alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU with a valid/ready handshake on both sides. Single-cycle logic, add,
//  sub, compare and shift ops sit beside iterative unsigned MUL and DIV. Produces ZF/CF/OF/SF/PF flags
//  and a HI word. Sits between decode and writeback of the Tiny-MIPS32 datapath.

---
 rtl/alu_mc.sv | 198 +++++++++++++++++++
 tb/tb_alu_mc.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the Tiny-MIPS32 datapath: single-cycle logic/arith/shift ops
// beside shift-add MULU and restoring DIVU, with valid/ready handshakes on both sides.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] HI,
  output logic             ZF,
  output logic             CF,
  output logic             OF,
  output logic             SF,
  output logic             PF,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_XOR  = 4'd2,  OP_NOR = 4'd3,
                         OP_ADD  = 4'd4,  OP_SUB  = 4'd5,  OP_SLT  = 4'd6,  OP_SLL = 4'd7,
                         OP_SRL  = 4'd8,  OP_SRA  = 4'd9,  OP_MULU = 4'd10, OP_DIVU = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] b_r, acc_hi, acc_lo;
  logic             op_mul_r;
  logic [SW-1:0]    cnt;
  logic             last, start_iter, load_res;

  // Single-cycle datapath, fed straight from the input operands at acceptance.
  logic [WIDTH:0]     sum, diff, srl_w, sra_w;
  logic [2*WIDTH-1:0] sll_w;
  logic [SW:0]        sh_amt;
  logic               sh_over;
  logic [WIDTH-1:0]   c_f, c_hi;
  logic               c_cf, c_of, c_err;

  assign sum     = {1'b0, A} + {1'b0, B};
  assign diff    = {1'b0, A} - {1'b0, B};
  assign sh_over = A > WIDTH'(WIDTH);
  assign sh_amt  = A[SW:0];
  // Widened shifts keep the last bit shifted out (and the lost SLL bits) alongside the result.
  assign sll_w   = {{WIDTH{1'b0}}, B} << sh_amt;
  assign srl_w   = {B, 1'b0} >> sh_amt;
  assign sra_w   = $signed({B, 1'b0}) >>> sh_amt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    c_f   = '0;
    c_hi  = '0;
    c_cf  = 1'b0;
    c_of  = 1'b0;
    c_err = 1'b0;
    case (op)
      OP_AND: c_f = A & B;
      OP_OR:  c_f = A | B;
      OP_XOR: c_f = A ^ B;
      OP_NOR: c_f = ~(A | B);
      OP_ADD: begin
        c_f  = sum[WIDTH-1:0];
        c_cf = sum[WIDTH];
        c_of = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_SLT: begin
        c_f  = (op == OP_SUB) ? diff[WIDTH-1:0]
                              : {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
        c_cf = diff[WIDTH];
        c_of = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL: begin
        c_f  = sh_over ? '0 : sll_w[WIDTH-1:0];
        c_cf = sh_over ? 1'b0 : sll_w[WIDTH];
        c_of = sh_over ? |B : |sll_w[2*WIDTH-1:WIDTH];
      end
      OP_SRL: begin
        c_f  = sh_over ? '0 : srl_w[WIDTH:1];
        c_cf = sh_over ? 1'b0 : srl_w[0];
      end
      OP_SRA: begin
        c_f  = sh_over ? {WIDTH{B[WIDTH-1]}} : sra_w[WIDTH:1];
        c_cf = sh_over ? B[WIDTH-1] : sra_w[0];
      end
      OP_MULU: ;
      OP_DIVU: begin
        // Only reaches the result registers for a zero divisor.
        c_f  = '1;
        c_hi = A;
        c_of = 1'b1;
      end
      default: c_err = 1'b1;
    endcase
  end

  // One iteration step; MULU and DIVU share acc_hi/acc_lo (product halves / remainder, quotient).
  logic [WIDTH:0]   mul_sum, div_tmp, div_sub;
  logic [WIDTH-1:0] it_hi, it_lo;

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_r} : '0);
  assign div_tmp = {acc_hi, acc_lo[WIDTH-1]};
  assign div_sub = div_tmp - {1'b0, b_r};
  assign it_hi   = op_mul_r ? mul_sum[WIDTH:1]
                            : (div_sub[WIDTH] ? div_tmp[WIDTH-1:0] : div_sub[WIDTH-1:0]);
  assign it_lo   = op_mul_r ? {mul_sum[0], acc_lo[WIDTH-1:1]}
                            : {acc_lo[WIDTH-2:0], ~div_sub[WIDTH]};

  assign last       = (cnt == SW'(WIDTH - 1));
  assign start_iter = (op == OP_MULU) || ((op == OP_DIVU) && (B != '0));
  assign load_res   = ((state == IDLE) && in_valid && !start_iter) || ((state == BUSY) && last);

  logic [WIDTH-1:0] res_f, res_hi;
  logic             res_cf, res_of, res_err;

  always_comb begin
    res_f   = c_f;
    res_hi  = c_hi;
    res_cf  = c_cf;
    res_of  = c_of;
    res_err = c_err;
    if (state == BUSY) begin
      res_f   = it_lo;
      res_hi  = it_hi;
      res_cf  = op_mul_r && (it_hi != '0);
      res_of  = op_mul_r && (it_hi != '0);
      res_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = start_iter ? BUSY : DONE;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_r      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      op_mul_r <= 1'b0;
      cnt      <= '0;
      F        <= '0;
      HI       <= '0;
      ZF       <= 1'b0;
      CF       <= 1'b0;
      OF       <= 1'b0;
      SF       <= 1'b0;
      PF       <= 1'b0;
      err      <= 1'b0;
    end else begin
      if ((state == IDLE) && in_valid) begin
        b_r      <= B;
        acc_hi   <= '0;
        acc_lo   <= A;
        op_mul_r <= (op == OP_MULU);
        cnt      <= '0;
        err      <= c_err;
      end else if (state == BUSY) begin
        acc_hi <= it_hi;
        acc_lo <= it_lo;
        if (!last) cnt <= cnt + SW'(1);
      end
      if (load_res) begin
        F  <= res_f;
        HI <= res_hi;
        ZF <= !res_err && (res_f == '0);
        CF <= res_cf;
        OF <= res_of;
        SF <= res_f[WIDTH-1];
        PF <= !res_err && ~^res_f[7:0];
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table of single/multi-cycle ops plus
// hand-written hold, reset-abort and no-accept-in-DONE sequences.
module tb_alu_mc;

  localparam int WIDTH = 32;
  localparam int LAT_M = WIDTH + 1;

  logic             clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, f, hi;
  logic [3:0]       op;
  logic             zf, cf, of_, sf, pf, err;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .F(f), .HI(hi), .ZF(zf), .CF(cf), .OF(of_), .SF(sf), .PF(pf), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, f, hi;
    logic [5:0]  fl;   // {err, ZF, CF, OF, SF, PF}
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(string n, logic [3:0] o, logic [31:0] va, vb, ef, eh,
                              logic [5:0] efl, int l);
    vec_t v;
    v.name = n; v.op = o; v.a = va; v.b = vb; v.f = ef; v.hi = eh; v.fl = efl; v.lat = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {err, zf, cf, of_, sf, pf};
  endfunction

  task automatic run_vec(input vec_t v);
    int  cyc;
    bit  got;
    check({v.name, " in_ready"}, 64'(in_ready), 64'd1);
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        in_valid = 1'b0; a = ~v.a; b = ~v.b; op = 4'd0;
      end
      if (out_valid) got = 1'b1;
    end
    check({v.name, " latency"}, 64'(cyc), 64'(v.lat));
    check({v.name, " F"}, 64'(f), 64'(v.f));
    check({v.name, " HI"}, 64'(hi), 64'(v.hi));
    check({v.name, " flags"}, 64'(flags()), 64'(v.fl));
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({v.name, " release"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;

    //          name        op     A            B            F            HI           eZCOSP     lat
    vecs.push_back(mk("and",    4'd0,  32'hacd438f4, 32'h1930a333, 32'h08102030, 32'h0, 6'b000001, 1));
    vecs.push_back(mk("add_of", 4'd4,  32'h7999aaaa, 32'h79990000, 32'hf332aaaa, 32'h0, 6'b000111, 1));
    vecs.push_back(mk("sub",    4'd5,  32'h0cd438f4, 32'h1930a333, 32'hf3a395c1, 32'h0, 6'b001010, 1));
    vecs.push_back(mk("sll9",   4'd7,  32'h00000009, 32'hacd438f4, 32'ha871e800, 32'h0, 6'b001111, 1));
    vecs.push_back(mk("sll_big",4'd7,  32'h00aaaaaa, 32'h000000aa, 32'h0,        32'h0, 6'b010101, 1));
    vecs.push_back(mk("sll32",  4'd7,  32'h00000020, 32'h00000003, 32'h0,        32'h0, 6'b011101, 1));
    vecs.push_back(mk("sll0",   4'd7,  32'h00000000, 32'h12345678, 32'h12345678, 32'h0, 6'b000001, 1));
    vecs.push_back(mk("ill13",  4'd13, 32'h12345678, 32'h9abcdef0, 32'h0,        32'h0, 6'b100000, 1));
    vecs.push_back(mk("or",     4'd1,  32'h0000f0f0, 32'h0f0f0000, 32'h0f0ff0f0, 32'h0, 6'b000001, 1));
    vecs.push_back(mk("xor",    4'd2,  32'hffffffff, 32'hffffffff, 32'h0,        32'h0, 6'b010001, 1));
    vecs.push_back(mk("nor",    4'd3,  32'h0,        32'h0,        32'hffffffff, 32'h0, 6'b000011, 1));
    vecs.push_back(mk("add_cf", 4'd4,  32'hffffffff, 32'h00000001, 32'h0,        32'h0, 6'b011001, 1));
    vecs.push_back(mk("slt_n1", 4'd6,  32'hffffffff, 32'h00000001, 32'h1,        32'h0, 6'b000000, 1));
    vecs.push_back(mk("slt_min",4'd6,  32'h80000000, 32'h00000001, 32'h1,        32'h0, 6'b000100, 1));
    vecs.push_back(mk("srl1",   4'd8,  32'h00000001, 32'h80000001, 32'h40000000, 32'h0, 6'b001001, 1));
    vecs.push_back(mk("srl32",  4'd8,  32'h00000020, 32'h80000000, 32'h0,        32'h0, 6'b011001, 1));
    vecs.push_back(mk("sra4",   4'd9,  32'h00000004, 32'h80000000, 32'hf8000000, 32'h0, 6'b000011, 1));
    vecs.push_back(mk("sra40",  4'd9,  32'h00000028, 32'h80000000, 32'hffffffff, 32'h0, 6'b001011, 1));
    vecs.push_back(mk("mul_hi", 4'd10, 32'h00010000, 32'h00010000, 32'h0,        32'h1, 6'b011101, LAT_M));
    vecs.push_back(mk("mul_lo", 4'd10, 32'h0000ffff, 32'h0000ffff, 32'hfffe0001, 32'h0, 6'b000010, LAT_M));
    vecs.push_back(mk("mul_max",4'd10, 32'hffffffff, 32'hffffffff, 32'h00000001, 32'hfffffffe, 6'b001100, LAT_M));
    vecs.push_back(mk("div",    4'd11, 32'd100,      32'd7,        32'd14,       32'd2, 6'b000000, LAT_M));
    vecs.push_back(mk("div0",   4'd11, 32'd5,        32'd0,        32'hffffffff, 32'd5, 6'b000111, 1));
    vecs.push_back(mk("div16",  4'd11, 32'hffffffff, 32'h00000010, 32'h0fffffff, 32'hf, 6'b000001, LAT_M));
    vecs.push_back(mk("div_sm", 4'd11, 32'd3,        32'd5,        32'd0,        32'd3, 6'b010001, LAT_M));

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset handshake", 64'({out_valid, in_ready}), 64'b01);
    check("reset F/HI", {f, hi}, 64'd0);
    check("reset flags", 64'(flags()), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Result held while out_ready=0; an op offered during DONE must be ignored.
    a = 32'h00010000; b = 32'h00010000; op = 4'd10; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(posedge clk); @(negedge clk);
    end
    check("hold valid", 64'(out_valid), 64'd1);
    a = 32'hffffffff; b = 32'hffffffff; op = 4'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold F/HI", {f, hi}, {32'h0, 32'h1});
      check("hold flags", 64'(flags()), 64'(6'b011101));
      check("hold handshake", 64'({out_valid, in_ready}), 64'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("hold release", 64'({out_valid, in_ready}), 64'b01);
    @(posedge clk); @(negedge clk);
    check("no accept in DONE", 64'({out_valid, in_ready}), 64'b01);

    // Reset in the middle of a MULU aborts it and clears every output.
    run_vec(mk("nor_pre", 4'd3, 32'h0, 32'h0, 32'hffffffff, 32'h0, 6'b000011, 1));
    a = 32'hffffffff; b = 32'hffffffff; op = 4'd10; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid-mul busy", 64'({out_valid, in_ready}), 64'b00);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("abort handshake", 64'({out_valid, in_ready}), 64'b01);
    check("abort F/HI", {f, hi}, 64'd0);
    check("abort flags", 64'(flags()), 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort no result", 64'(seen), 64'd0);
    run_vec(mk("ill15", 4'd15, 32'hffffffff, 32'hffffffff, 32'h0, 32'h0, 6'b100000, 1));
    run_vec(mk("err_clr", 4'd0, 32'hffffffff, 32'h0000000f, 32'h0000000f, 32'h0, 6'b000001, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
